// File: rtl/gene_net_sweep_ctrl_if.sv
// -----------------------------------------------------------------------------
// gene_net_sweep_ctrl_if
// Result-record stream produced by gene_net_sweep_ctrl.
//
// Handshake: the producer raises res_valid with all res_* fields stable and
// keeps them unchanged until it samples res_valid && res_ready on a rising
// clock edge. That edge is the transfer. The consumer may hold res_ready low
// for as long as it likes. res_ready may be asserted before res_valid.
//
// Signals
//   res_valid  producer -> consumer  record present
//   res_ready  consumer -> producer  record accepted
//   res_init   producer -> consumer  init value of the reported run
//   res_kind   producer -> consumer  01 fixed, 10 cycle, 11 timeout
//   res_steps  producer -> consumer  RUN cycles elapsed at detection
//   res_final  producer -> consumer  gene_net state captured at detection
// -----------------------------------------------------------------------------
interface gene_net_sweep_ctrl_if #(
   parameter int WIDTH = 8
);
   logic             res_valid;
   logic             res_ready;
   logic [WIDTH-1:0] res_init;
   logic [1:0]       res_kind;
   logic [WIDTH:0]   res_steps;
   logic [WIDTH-1:0] res_final;

   modport master (
      output res_valid,
      output res_init,
      output res_kind,
      output res_steps,
      output res_final,
      input  res_ready
   );

   modport slave (
      input  res_valid,
      input  res_init,
      input  res_kind,
      input  res_steps,
      input  res_final,
      output res_ready
   );
endinterface

// File: rtl/gene_net_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// gene_net_sweep_ctrl
// Sweeps every nonzero initial state 1..2^WIDTH-1 through the gene network.
// For each init value it holds the value for SETTLE cycles (LOAD). It then
// watches the fixed-point / cycle checker flags for up to MAX_STEPS cycles
// (RUN). It reports the outcome as one record on the result stream (REPORT).
//
// Build option: define SWEEP_STATS_EN to build the saturating outcome tallies.
// Without it, fixed_cnt/cycle_cnt/timeout_cnt are tied to zero.
//
// Ports
//   clk, rst      rising-edge clock, synchronous active-high reset
//   start         begin a sweep (honoured in IDLE and DONE only)
//   init_val_out  init value driven to gene_net / checkers (init_val_chk)
//   x_in          current gene_net state
//   fixed_in      fixed-point checker flag
//   cycle_in      cycle checker flag
//   res           result record stream (gene_net_sweep_ctrl_if.master)
//   busy          high in LOAD / RUN / REPORT
//   done          sweep complete (DONE state)
//   fixed_cnt, cycle_cnt, timeout_cnt  outcome tallies
//   state_dbg     current FSM state encoding (IDLE=0 LOAD=1 RUN=2 REPORT=3
//                 DONE=4)
// -----------------------------------------------------------------------------
module gene_net_sweep_ctrl #(
   parameter int WIDTH     = 8,
   parameter int SETTLE    = 2,
   parameter int MAX_STEPS = 300
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   output logic [WIDTH-1:0]       init_val_out,
   input  logic [WIDTH-1:0]       x_in,
   input  logic                   fixed_in,
   input  logic                   cycle_in,
   gene_net_sweep_ctrl_if.master  res,
   output logic                   busy,
   output logic                   done,
   output logic [WIDTH-1:0]       fixed_cnt,
   output logic [WIDTH-1:0]       cycle_cnt,
   output logic [WIDTH-1:0]       timeout_cnt,
   output logic [2:0]             state_dbg
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOAD   = 3'd1,
      S_RUN    = 3'd2,
      S_REPORT = 3'd3,
      S_DONE   = 3'd4
   } state_t;

   localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [WIDTH-1:0] INIT_LAST = '1;
   localparam logic [1:0] KIND_FIXED   = 2'b01;
   localparam logic [1:0] KIND_CYCLE   = 2'b10;
   localparam logic [1:0] KIND_TIMEOUT = 2'b11;

   state_t           state, state_next;
   logic [SW-1:0]    settle_cnt;
   logic [WIDTH:0]   step_cnt;
   logic [WIDTH-1:0] init_q;
   logic [WIDTH-1:0] res_init_q;
   logic [1:0]       res_kind_q;
   logic [WIDTH:0]   res_steps_q;
   logic [WIDTH-1:0] res_final_q;

   // Control strobes decoded by the next-state logic.
   logic       start_sweep;
   logic       run_exit;
   logic [1:0] kind_next;
   logic       xfer;
   logic       settle_last;
   logic       step_last;

   assign settle_last = (settle_cnt == SW'(SETTLE - 1));
   assign step_last   = (step_cnt == (WIDTH+1)'(MAX_STEPS - 1));

   // ---------------------------------------------------------------- state reg
   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_next;
   end

   // ------------------------------------------------- next state and outputs
   always_comb begin
      state_next  = state;
      start_sweep = 1'b0;
      run_exit    = 1'b0;
      kind_next   = 2'b00;
      xfer        = 1'b0;
      busy        = 1'b0;
      done        = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               start_sweep = 1'b1;
               state_next  = S_LOAD;
            end
         end
         S_LOAD: begin
            busy = 1'b1;
            // Checker flags reflect the previous init value here; ignore them.
            if (settle_last) state_next = S_RUN;
         end
         S_RUN: begin
            busy = 1'b1;
            // Fixed wins over cycle, and either flag wins over the timeout.
            if (fixed_in) begin
               run_exit  = 1'b1;
               kind_next = KIND_FIXED;
            end else if (cycle_in) begin
               run_exit  = 1'b1;
               kind_next = KIND_CYCLE;
            end else if (step_last) begin
               run_exit  = 1'b1;
               kind_next = KIND_TIMEOUT;
            end
            if (run_exit) state_next = S_REPORT;
         end
         S_REPORT: begin
            busy = 1'b1;
            if (res.res_ready) begin
               xfer       = 1'b1;
               state_next = (init_q == INIT_LAST) ? S_DONE : S_LOAD;
            end
         end
         S_DONE: begin
            done = 1'b1;
            if (start) begin
               start_sweep = 1'b1;
               state_next  = S_LOAD;
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

   // ---------------------------------------------------------------- datapath
   always_ff @(posedge clk) begin
      if (rst) begin
         init_q      <= '0;
         settle_cnt  <= '0;
         step_cnt    <= '0;
         res_init_q  <= '0;
         res_kind_q  <= '0;
         res_steps_q <= '0;
         res_final_q <= '0;
      end else begin
         if (start_sweep) begin
            init_q     <= WIDTH'(1);
            settle_cnt <= '0;
         end
         if (state == S_LOAD) begin
            settle_cnt <= settle_cnt + 1'b1;
            step_cnt   <= '0;
         end
         if (state == S_RUN) begin
            step_cnt <= step_cnt + 1'b1;
            if (run_exit) begin
               res_init_q  <= init_q;
               res_kind_q  <= kind_next;
               res_steps_q <= step_cnt + 1'b1;
               res_final_q <= x_in;
            end
         end
         // After the last init value the bus returns to the 0 sentinel.
         if (xfer) begin
            settle_cnt <= '0;
            if (init_q == INIT_LAST) init_q <= '0;
            else                     init_q <= init_q + 1'b1;
         end
      end
   end

   // ----------------------------------------------------------------- tallies
`ifdef SWEEP_STATS_EN
   logic [WIDTH-1:0] fixed_q, cycle_q, timeout_q;

   always_ff @(posedge clk) begin
      if (rst || start_sweep) begin
         fixed_q   <= '0;
         cycle_q   <= '0;
         timeout_q <= '0;
      end else if (xfer) begin
         // Saturate at all-ones rather than wrapping.
         case (res_kind_q)
            KIND_FIXED:   if (fixed_q   != '1) fixed_q   <= fixed_q   + 1'b1;
            KIND_CYCLE:   if (cycle_q   != '1) cycle_q   <= cycle_q   + 1'b1;
            KIND_TIMEOUT: if (timeout_q != '1) timeout_q <= timeout_q + 1'b1;
            default: ;
         endcase
      end
   end

   assign fixed_cnt   = fixed_q;
   assign cycle_cnt   = cycle_q;
   assign timeout_cnt = timeout_q;
`else
   assign fixed_cnt   = '0;
   assign cycle_cnt   = '0;
   assign timeout_cnt = '0;
`endif

   // ----------------------------------------------------------------- outputs
   assign init_val_out  = init_q;
   assign res.res_valid = (state == S_REPORT);
   assign res.res_init  = res_init_q;
   assign res.res_kind  = res_kind_q;
   assign res.res_steps = res_steps_q;
   assign res.res_final = res_final_q;
   assign state_dbg     = state;

endmodule

// File: doc/gene_net_sweep_ctrl.md
# gene_net_sweep_ctrl

Sequencer for the gene-network exploration datapath. It sweeps every nonzero initial state 1..2^WIDTH-1 through the gene network, then waits for the fixed-point or cycle checker flag, or a step timeout. Each run's outcome is emitted as a ready/valid result record. It sits between the testbench/host and the gene_net, fixed-point checker and cycle checker instances, whose shared `init_val_chk` input it drives.

## Interface
- WIDTH, 8, state width of the gene network
- SETTLE, 2, cycles held in LOAD after a new init value before flags are trusted (≥1)
- MAX_STEPS, 300, RUN cycles before a run is declared timeout (≤ 2^(WIDTH+1)-1)
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  begin sweep; sampled in IDLE or DONE only
- init_val_out  out  WIDTH  init value driven to gene_net/checkers' `init_val_chk`
- x_in  in  WIDTH  current gene_net state
- fixed_in  in  1  fixed-point checker flag
- cycle_in  in  1  cycle checker flag
- res_valid  out  1  result record valid
- res_ready  in  1  consumer accepts record
- res_init  out  WIDTH  init value of reported run
- res_kind  out  2  01 fixed, 10 cycle, 11 timeout
- res_steps  out  WIDTH+1  RUN cycles elapsed at detection
- res_final  out  WIDTH  x_in captured at detection
- busy  out  1  high in LOAD/RUN/REPORT
- done  out  1  sweep complete
- fixed_cnt, cycle_cnt, timeout_cnt  out  WIDTH each  outcome tallies

## Operation
- States: IDLE, LOAD, RUN, REPORT, DONE.
- IDLE: on start -> LOAD with init_val_out=1, counters cleared.
- LOAD: init_val_out held and settle counter runs; after SETTLE cycles -> RUN, step counter=0. Flags are ignored.
- RUN: step counter +1 per cycle.
  - fixed_in -> REPORT, kind 01.
  - else cycle_in -> REPORT, kind 10. fixed has priority when both are high.
  - else step counter == MAX_STEPS-1 -> REPORT, kind 11.
  - On exit: res_steps = step counter +1, res_final = x_in, res_init = init_val_out.
- REPORT: res_valid=1; record fields stable until handshake. On res_valid&&res_ready the matching tally increments (saturating at 2^WIDTH-1).
  - If init_val_out == 2^WIDTH-1 -> DONE.
  - Otherwise init_val_out+1 -> LOAD.
- Init value 0 is never driven during a sweep; it remains the codebase's end-of-stimulus sentinel.
- DONE: done=1, init_val_out=0. Tallies are held. start -> LOAD with init 1, counters cleared, done cleared.
- start while busy is ignored.

## Timing
- Reset (any state, mid-run included): state IDLE; init_val_out=0, res_*=0, res_valid=0, busy=0, done=0, all tallies 0. Next cycle behaves as fresh IDLE.
- Start latency: start high at edge N -> init_val_out=1 and busy=1 after edge N.
- RUN entered SETTLE cycles after LOAD entry.
- Detection at edge M (flag high in RUN) -> res_valid=1 after edge M.
- Handshake at edge K -> res_valid=0 and state LOAD (or DONE) after edge K. No back-to-back records: at least SETTLE+1 cycles between res_valid pulses.
- res_ready held low stalls indefinitely. Outputs are frozen and no new run starts.
- Timeout boundary: a flag in the same cycle as step MAX_STEPS-1 reports the flag kind, not timeout.
- Tally saturation: no wrap.
- Wrap-around: init_val_out never increments past 2^WIDTH-1.

## Configuration
- SWEEP_STATS_EN defined: fixed_cnt/cycle_cnt/timeout_cnt implemented as above.
- Undefined: tally registers are not built. The three ports are tied to 0 and the ports remain present. FSM and result stream are unaffected.

## Test plan
- Reset/start: rst 3 cycles, then start pulse -> all outputs 0 during reset; init_val_out=1, busy=1 one edge after start.
- Fixed detection: bench asserts fixed_in 5 RUN cycles after entry with x_in=8'h3C -> res_kind=01, res_steps=6, res_final=8'h3C, res_init=1. With SWEEP_STATS_EN, fixed_cnt=1 after handshake.
- Priority/timeout: fixed_in and cycle_in high together -> kind 01. Flags never high -> kind 11 with res_steps=MAX_STEPS.
- Backpressure: res_ready low 10 cycles during REPORT -> record fields unchanged, init_val_out unchanged, no LOAD entry. res_ready high -> next cycle LOAD with init_val_out+1.
- Full sweep: res_ready tied 1, cycle_in asserted every RUN -> 255 records with res_init 1..255 in order. Then done=1, init_val_out=0, and cycle_cnt=255 (or 0 without SWEEP_STATS_EN).
- Reset mid-run: rst during RUN of init 0x40 -> IDLE, res_valid=0, tallies 0. A following start restarts at init 1.
